br_pred_update_sched: RTL

//  Sequences all writes into the branch pattern history table (PHT). Buffers resolved-branch

---
 rtl/br_pred_update_sched.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/br_pred_update_sched.sv
`default_nettype none
// ============================================================================
// Module      : br_pred_update_sched
// Description : Branch PHT update sequencer. Queues resolved WB branches and
//               performs a 2-cycle read-modify-write per update. Also owns the
//               weakly-not-taken init sweep after reset/flush.
//               Optional statistics counters: define BR_PRED_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module br_pred_update_sched #(
    parameter int INDEX_W    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_req,
    input  logic               upd_valid,
    input  logic [15:0]        upd_pc,
    input  logic               upd_taken,
    input  logic               upd_pred_taken,
    output logic               upd_ready,
    output logic [INDEX_W-1:0] pht_rd_index,
    input  logic [1:0]         pht_rd_state,
    output logic               pht_we,
    output logic [INDEX_W-1:0] pht_wr_index,
    output logic [1:0]         pht_wr_state,
    output logic               init_busy
`ifdef BR_PRED_STATS_EN
    ,
    output logic [15:0]        stat_branches,
    output logic [15:0]        stat_mispredicts
`endif
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_ptr_w-1:0] c_ptr_one = 1;
    localparam logic [c_cnt_w-1:0] c_cnt_one = 1;
    localparam logic [INDEX_W-1:0] c_idx_one = 1;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [INDEX_W-1:0]   r_sweep;
    logic [INDEX_W-1:0]   r_fifo_idx [FIFO_DEPTH];
    logic                 r_fifo_tkn [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;
    logic [c_cnt_w-1:0]   w_count_nxt;
    logic [INDEX_W-1:0]   r_work_idx;
    logic                 r_work_tkn;
    logic [1:0]           r_work_state;
    logic [INDEX_W-1:0]   r_wr_index_q;
    logic [1:0]           r_wr_state_q;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_we;
    logic [INDEX_W-1:0]   w_wr_index;
    logic [1:0]           w_wr_state;
    logic                 w_unused_ok;

    // Only upd_pc[INDEX_W:1] indexes the table; other bits are don't-care.
    assign w_unused_ok = ^{upd_pred_taken, upd_pc};

    function automatic logic [1:0] sat2(input logic [1:0] s, input logic t);
        if (t) return (s == 2'b11) ? s : s + 2'b01;
        else   return (s == 2'b00) ? s : s - 2'b01;
    endfunction

    // Ready is based on the registered count only: no pass-through when full.
    assign upd_ready    = (r_state != ST_INIT) && !r_count[c_ptr_w];
    assign w_push       = upd_valid && upd_ready;
    assign w_pop        = (r_state == ST_READ);
    assign init_busy    = (r_state == ST_INIT);
    assign pht_rd_index = (r_state == ST_READ) ? r_fifo_idx[r_rd_ptr] : '0;
    assign pht_we       = w_we && !rst;
    assign pht_wr_index = w_wr_index;
    assign pht_wr_state = w_wr_state;

    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_cnt_one;
            2'b01:   w_count_nxt = r_count - c_cnt_one;
            default: w_count_nxt = r_count;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_wr_index  = r_wr_index_q;
        w_wr_state  = r_wr_state_q;
        unique case (r_state)
            ST_INIT: begin
                w_we       = 1'b1;
                w_wr_index = r_sweep;
                w_wr_state = 2'b01;
                if (r_sweep == {INDEX_W{1'b1}}) w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (r_count != '0) w_state_nxt = ST_READ;
            end
            ST_READ: begin
                w_state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                w_we        = 1'b1;
                w_wr_index  = r_work_idx;
                w_wr_state  = sat2(r_work_state, r_work_tkn);
                w_state_nxt = (w_count_nxt != '0) ? ST_READ : ST_IDLE;
            end
            default: w_state_nxt = ST_INIT;
        endcase
        if (flush_req) w_state_nxt = ST_INIT;
    end

    always_ff @(posedge clk) begin
        if (rst || flush_req) begin
            r_state  <= ST_INIT;
            r_sweep  <= '0;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            if (r_state == ST_INIT) r_sweep  <= r_sweep + c_idx_one;
            if (w_push)             r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop)              r_rd_ptr <= r_rd_ptr + c_ptr_one;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_idx[r_wr_ptr] <= upd_pc[INDEX_W:1];
            r_fifo_tkn[r_wr_ptr] <= upd_taken;
        end
        if (r_state == ST_READ) begin
            r_work_idx   <= r_fifo_idx[r_rd_ptr];
            r_work_tkn   <= r_fifo_tkn[r_rd_ptr];
            r_work_state <= pht_rd_state;
        end
    end

    // Write-port hold registers; a WRITE coincident with flush still lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_index_q <= '0;
            r_wr_state_q <= 2'b01;
        end else if (pht_we) begin
            r_wr_index_q <= w_wr_index;
            r_wr_state_q <= w_wr_state;
        end
    end

`ifdef BR_PRED_STATS_EN
    logic [15:0] r_stat_br;
    logic [15:0] r_stat_mis;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_br  <= '0;
            r_stat_mis <= '0;
        end else if (w_push && !flush_req) begin
            if (r_stat_br != 16'hFFFF) r_stat_br <= r_stat_br + 16'd1;
            if ((upd_pred_taken != upd_taken) && (r_stat_mis != 16'hFFFF))
                r_stat_mis <= r_stat_mis + 16'd1;
        end
    end

    assign stat_branches    = r_stat_br;
    assign stat_mispredicts = r_stat_mis;
`endif

endmodule
`default_nettype wire
